// File: rtl/jk_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jk_cmd_sequencer
// Description : Queues timed hold/reset/set/toggle commands and plays them
//               out on registered j/k lines for a downstream JK flip-flop.
//               Define JK_SEQ_READBACK_EN to add the q/qnot readback checker.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [CNT_W-1:0]         cmd_len,
    output logic                     j,
    output logic                     k,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef JK_SEQ_READBACK_EN
    ,
    input  logic                     q,
    input  logic                     qnot,
    output logic                     mismatch,
    output logic [7:0]               err_count
`endif
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam logic [c_AW-1:0]  c_PTR_ONE  = c_AW'(1);
    localparam logic [c_LW-1:0]  c_LVL_ONE  = c_LW'(1);
    localparam logic [c_LW-1:0]  c_LVL_FULL = c_LW'(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    logic [1:0]       r_op_mem  [DEPTH];
    logic [CNT_W-1:0] r_len_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_j;
    logic             r_k;

    logic             w_push;
    logic             w_pop;
    logic             w_seek;
    logic             w_head_vld;
    logic [1:0]       w_head_op;
    logic [CNT_W-1:0] w_head_len;

    // Readiness comes from the registered level only, so a full FIFO never
    // accepts in the same cycle as a pop.
    assign cmd_ready  = (r_level < c_LVL_FULL);
    assign w_push     = cmd_valid && cmd_ready;
    assign w_head_vld = (r_level != '0);
    assign w_head_op  = r_op_mem[r_rd_ptr];
    assign w_head_len = r_len_mem[r_rd_ptr];

    // The sequencer looks for the next command when idle or on the final
    // cycle of a run; a zero-length head is consumed there as well.
    assign w_seek = (r_state == ST_IDLE) || (r_cnt == c_CNT_ONE);
    assign w_pop  = w_seek && w_head_vld;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem[r_wr_ptr]  <= cmd_op;
            r_len_mem[r_wr_ptr] <= cmd_len;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_j     <= 1'b0;
            r_k     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DRIVE: begin
                    if (w_seek) begin
                        if (w_head_vld && (w_head_len != '0)) begin
                            r_state <= ST_DRIVE;
                            r_cnt   <= w_head_len;
                            r_j     <= w_head_op[1];
                            r_k     <= w_head_op[0];
                        end else begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_j     <= 1'b0;
                            r_k     <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_j     <= 1'b0;
                    r_k     <= 1'b0;
                end
            endcase
        end
    end

    assign j          = r_j;
    assign k          = r_k;
    assign fifo_level = r_level;
    assign busy       = (r_state == ST_DRIVE) || w_head_vld;

`ifdef JK_SEQ_READBACK_EN
    logic       r_q_exp;
    logic       r_mismatch;
    logic [7:0] r_err_count;
    logic       w_bad;

    assign w_bad = (q != r_q_exp) || (qnot != ~q);

    // Tracks the flip-flop from the same j/k it is being driven with.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q_exp     <= 1'b0;
            r_mismatch  <= 1'b0;
            r_err_count <= '0;
        end else begin
            case ({r_j, r_k})
                2'b01:   r_q_exp <= 1'b0;
                2'b10:   r_q_exp <= 1'b1;
                2'b11:   r_q_exp <= ~r_q_exp;
                default: r_q_exp <= r_q_exp;
            endcase
            r_mismatch <= w_bad;
            if (w_bad && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign mismatch  = r_mismatch;
    assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire
